// File: rtl/fp16_pkg.sv
// fp16_pkg: shared FP16 field widths and field-slice helpers.
// Used by the multiplier core and the arbiter top.
//   FP16_W   total word width
//   EXP_W    exponent field width
//   MAN_W    stored mantissa field width
//   EXP_BIAS exponent bias
package fp16_pkg;

   localparam int unsigned FP16_W   = 16;
   localparam int unsigned EXP_W    = 5;
   localparam int unsigned MAN_W    = 10;
   localparam int unsigned EXP_BIAS = 15;

   typedef logic [FP16_W-1:0] fp16_t;

   function automatic logic fp_sign(fp16_t x);
      return x[FP16_W-1];
   endfunction

   function automatic logic [EXP_W-1:0] fp_exp(fp16_t x);
      return x[FP16_W-2 -: EXP_W];
   endfunction

   function automatic logic [MAN_W-1:0] fp_man(fp16_t x);
      return x[MAN_W-1:0];
   endfunction

   function automatic fp16_t fp_pack(logic s, logic [EXP_W-1:0] e, logic [MAN_W-1:0] m);
      return {s, e, m};
   endfunction

endpackage

// File: rtl/fp16_mul_arbiter_if.sv
// fp16_mul_arbiter_if: request and result channels of the shared FP16 multiplier.
//   req_valid/req_ready  per-requester operand handshake (ready is one-hot or zero)
//   req_a/req_b          operands, requester i in bits [16i+15:16i]
//   res_valid/res_ready  result handshake
//   res_data/res_id      packed FP16 product and issuing requester index
// master: requesters plus result consumer; slave: the arbiter.
interface fp16_mul_arbiter_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
);

   logic [NREQ-1:0]                  req_valid;
   logic [NREQ-1:0]                  req_ready;
   logic [fp16_pkg::FP16_W*NREQ-1:0] req_a;
   logic [fp16_pkg::FP16_W*NREQ-1:0] req_b;
   logic                             res_valid;
   logic                             res_ready;
   logic [fp16_pkg::FP16_W-1:0]      res_data;
   logic [IDW-1:0]                   res_id;

   modport master (
      output req_valid, req_a, req_b, res_ready,
      input  req_ready, res_valid, res_data, res_id
   );

   modport slave (
      input  req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_data, res_id
   );

endinterface

// File: rtl/flop_mul.sv
// flop_mul: combinational FP16 multiplier core.
//   flp_a, flp_b  operands
//   sign          product sign
//   exponent      product exponent, wraps mod 32 (no overflow/underflow handling)
//   prod          product mantissa, truncated (no rounding)
// An exact 16'h0000 operand forces an all-zero result; 16'h8000 is a normal operand.
module flop_mul
   import fp16_pkg::*;
(
   input  fp16_t            flp_a,
   input  fp16_t            flp_b,
   output logic             sign,
   output logic [EXP_W-1:0] exponent,
   output logic [MAN_W-1:0] prod
);

   localparam int unsigned ProdW = 2 * MAN_W + 2;

   logic [ProdW-1:0] m_raw;
   logic [EXP_W-1:0] e_raw;
   logic             unused_m_lsb;

   always_comb begin
      m_raw = ProdW'({1'b1, fp_man(flp_a)}) * ProdW'({1'b1, fp_man(flp_b)});
      // Bias removed once, plus one so the m[21]=1 case needs no adjust.
      e_raw = fp_exp(flp_a) + fp_exp(flp_b) - EXP_W'(EXP_BIAS - 1);

      sign = fp_sign(flp_a) ^ fp_sign(flp_b);
      if (m_raw[ProdW-1]) begin
         exponent = e_raw;
         prod     = m_raw[ProdW-2 -: MAN_W];
      end else begin
         // Equivalent to shifting m left by one and taking m[20:11].
         exponent = e_raw - EXP_W'(1);
         prod     = m_raw[ProdW-3 -: MAN_W];
      end

      if (flp_a == '0 || flp_b == '0) begin
         sign     = 1'b0;
         exponent = '0;
         prod     = '0;
      end
   end

   // Truncated product bits are intentionally dropped.
   assign unused_m_lsb = ^m_raw[MAN_W-1:0];

endmodule

// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: round-robin sharing of one FP16 multiplier among NREQ requesters.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of fp16_mul_arbiter_if (request and result channels)
// Two-stage pipeline: S1 registers the granted operands, S2 registers the packed
// product and drives the result channel directly. Accept in cycle N gives
// res_valid in cycle N+2; one result per cycle while res_ready is high.
// IDW must equal clog2(NREQ).
module fp16_mul_arbiter
   import fp16_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   fp16_mul_arbiter_if.slave bus
);

   fp16_t req_a_arr [NREQ];
   fp16_t req_b_arr [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_a_arr[gi] = bus.req_a[gi*FP16_W +: FP16_W];
      assign req_b_arr[gi] = bus.req_b[gi*FP16_W +: FP16_W];
   end

   logic           s1_vld_q, s1_vld_d;
   fp16_t          s1_a_q, s1_a_d;
   fp16_t          s1_b_q, s1_b_d;
   logic [IDW-1:0] s1_id_q, s1_id_d;
   logic           s2_vld_q, s2_vld_d;
   fp16_t          s2_data_q, s2_data_d;
   logic [IDW-1:0] s2_id_q, s2_id_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

   logic s2_adv, s1_adv;

   assign s2_adv = !s2_vld_q || bus.res_ready;
   assign s1_adv = !s1_vld_q || s2_adv;

   // Round-robin search starting at rr_ptr.
   logic [IDW-1:0]  grant_id;
   logic [IDW-1:0]  idx;
   logic            found;
   logic            xfer;
   logic [NREQ-1:0] grant;

   always_comb begin
      found    = 1'b0;
      grant_id = '0;
      idx      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = IDW'((32'(rr_ptr_q) + k) % NREQ);
         if (!found && bus.req_valid[idx]) begin
            found    = 1'b1;
            grant_id = idx;
         end
      end
   end

   // Gating with rst_n keeps req_ready low while reset is held.
   assign xfer = found && s1_adv && rst_n;

   always_comb begin
      grant = '0;
      if (xfer) begin
         grant[grant_id] = 1'b1;
      end
   end

   assign bus.req_ready = grant;

   logic             mul_sign;
   logic [EXP_W-1:0] mul_exp;
   logic [MAN_W-1:0] mul_prod;

   flop_mul u_flop_mul (
      .flp_a    (s1_a_q),
      .flp_b    (s1_b_q),
      .sign     (mul_sign),
      .exponent (mul_exp),
      .prod     (mul_prod)
   );

   always_comb begin
      s1_vld_d  = s1_vld_q;
      s1_a_d    = s1_a_q;
      s1_b_d    = s1_b_q;
      s1_id_d   = s1_id_q;
      s2_vld_d  = s2_vld_q;
      s2_data_d = s2_data_q;
      s2_id_d   = s2_id_q;
      rr_ptr_d  = rr_ptr_q;

      if (s1_adv) begin
         s1_vld_d = xfer;
         if (xfer) begin
            s1_a_d  = req_a_arr[grant_id];
            s1_b_d  = req_b_arr[grant_id];
            s1_id_d = grant_id;
         end
      end

      if (s2_adv) begin
         s2_vld_d = s1_vld_q;
         // Only capture real products so the outputs stay quiet when idle.
         if (s1_vld_q) begin
            s2_data_d = fp_pack(mul_sign, mul_exp, mul_prod);
            s2_id_d   = s1_id_q;
         end
      end

      if (xfer) begin
         rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         s1_id_q   <= '0;
         s2_vld_q  <= 1'b0;
         s2_data_q <= '0;
         s2_id_q   <= '0;
         rr_ptr_q  <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_a_q    <= s1_a_d;
         s1_b_q    <= s1_b_d;
         s1_id_q   <= s1_id_d;
         s2_vld_q  <= s2_vld_d;
         s2_data_q <= s2_data_d;
         s2_id_q   <= s2_id_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   assign bus.res_valid = s2_vld_q;
   assign bus.res_data  = s2_data_q;
   assign bus.res_id    = s2_id_q;

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// tb_fp16_mul_arbiter: scoreboard bench for fp16_mul_arbiter.
// Transfers push the hand-computed product into a queue; a monitor pops and
// compares on every accepted result.
module tb_fp16_mul_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned IDW  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fp16_mul_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   fp16_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int          id;
      logic [15:0] data;
      int          cyc;
      bit          lat;
   } exp_t;

   exp_t        sb[$];
   int          grant_log[$];
   int          res_cyc_log[$];
   logic [15:0] exp_data [NREQ];
   exp_t        trk_e;
   exp_t        mon_e;
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          res_cnt = 0;
   bit          lat_chk = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Transfer tracker: records grants and pushes expected results.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
               trk_e.id   = i;
               trk_e.data = exp_data[i];
               trk_e.cyc  = cyc;
               trk_e.lat  = lat_chk;
               sb.push_back(trk_e);
               grant_log.push_back(i);
            end
         end
      end
   end

   // Result monitor.
   always @(negedge clk) begin
      if (rst_n && bus.res_valid && bus.res_ready) begin
         res_cnt++;
         res_cyc_log.push_back(cyc);
         if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_result: actual id=%0d data=%h required=none",
                     bus.res_id, bus.res_data);
         end else begin
            mon_e = sb.pop_front();
            chk("res_data", 32'(bus.res_data), 32'(mon_e.data));
            chk("res_id", 32'(bus.res_id), 32'(mon_e.id));
            if (mon_e.lat) chk("latency", 32'(cyc - mon_e.cyc), 32'd2);
         end
      end
   end

   task automatic set_req(int i, logic [15:0] a, logic [15:0] b, logic [15:0] e);
      bus.req_a[i*16 +: 16] = a;
      bus.req_b[i*16 +: 16] = b;
      exp_data[i] = e;
   endtask

   // One cycle; requesters drop valid after their transfer.
   task automatic step();
      logic [NREQ-1:0] x;
      @(negedge clk);
      x = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      bus.req_valid = bus.req_valid & ~x;
   endtask

   task automatic issue(int i);
      bit done = 1'b0;
      bus.req_valid[i] = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         step();
         if (!bus.req_valid[i]) done = 1'b1;
      end
      if (!done) begin
         bus.req_valid[i] = 1'b0;
         chk("issue_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 50 && sb.size() != 0; k++) step();
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   int res_cnt0;

   initial begin
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.res_ready = 1'b1;
      bus.req_valid = '1;
      rst_n         = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_res_data", 32'(bus.res_data), 32'd0);
      chk("rst_res_id", 32'(bus.res_id), 32'd0);
      bus.req_valid = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single request with latency check.
      set_req(0, 16'h3C00, 16'h3C00, 16'h3C00);
      lat_chk = 1'b1;
      issue(0);
      drain();
      lat_chk = 1'b0;

      // Directed arithmetic vectors.
      set_req(2, 16'h4000, 16'h4200, 16'h4600); issue(2);
      set_req(1, 16'hBE00, 16'h4000, 16'hC200); issue(1);
      set_req(3, 16'h0000, 16'h4000, 16'h0000); issue(3);
      set_req(0, 16'h8000, 16'h3C00, 16'h8000); issue(0);
      set_req(1, 16'h7C00, 16'h7C00, 16'h3C00); issue(1);
      set_req(2, 16'h3E00, 16'h3E00, 16'h4080); issue(2);
      set_req(3, 16'h4000, 16'h0000, 16'h0000); issue(3);
      drain();

      // All requesters valid from reset.
      rst_n = 1'b0;
      set_req(0, 16'h3C00, 16'h3C00, 16'h3C00);
      set_req(1, 16'h4000, 16'h4200, 16'h4600);
      set_req(2, 16'hBE00, 16'h4000, 16'hC200);
      set_req(3, 16'h3E00, 16'h3E00, 16'h4080);
      bus.req_valid = '1;
      @(posedge clk);
      #1;
      grant_log.delete();
      res_cyc_log.delete();
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus.req_valid = '1;
         step();
      end
      bus.req_valid = '0;
      drain();
      chk("rot_count", 32'(grant_log.size()), 32'd8);
      for (int k = 0; k < 8 && k < grant_log.size(); k++)
         chk("rot_order", 32'(grant_log[k]), 32'(k % 4));
      chk("thru_count", 32'(res_cyc_log.size()), 32'd8);
      if (res_cyc_log.size() == 8)
         chk("thru_span", 32'(res_cyc_log[7] - res_cyc_log[0]), 32'd7);

      // Backpressure with three queued requests.
      set_req(0, 16'h4000, 16'h4000, 16'h4400);
      set_req(1, 16'h3C00, 16'h4200, 16'h4200);
      set_req(2, 16'hC000, 16'h3C00, 16'hC000);
      bus.res_ready = 1'b0;
      bus.req_valid = 4'b0111;
      for (int c = 1; c <= 5; c++) begin
         step();
         if (c >= 2) begin
            chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_res_data", 32'(bus.res_data), 32'h4400);
            chk("bp_res_id", 32'(bus.res_id), 32'd0);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
         end
      end
      bus.res_ready = 1'b1;
      for (int k = 0; k < 20 && bus.req_valid != '0; k++) step();
      drain();

      // Wrap between requesters 3 and 0.
      set_req(3, 16'h4000, 16'h4200, 16'h4600);
      set_req(0, 16'hBE00, 16'h4000, 16'hC200);
      grant_log.delete();
      for (int k = 0; k < 3; k++) begin
         bus.req_valid = 4'b1001;
         step();
      end
      bus.req_valid = '0;
      drain();
      chk("wrap_count", 32'(grant_log.size()), 32'd3);
      if (grant_log.size() == 3) begin
         chk("wrap_g0", 32'(grant_log[0]), 32'd3);
         chk("wrap_g1", 32'(grant_log[1]), 32'd0);
         chk("wrap_g2", 32'(grant_log[2]), 32'd3);
      end

      // Reset with both stages full.
      set_req(0, 16'h3C00, 16'h3C00, 16'h3C00);
      set_req(1, 16'h4000, 16'h4200, 16'h4600);
      set_req(2, 16'h3E00, 16'h3E00, 16'h4080);
      bus.res_ready = 1'b0;
      bus.req_valid = 4'b0011;
      repeat (3) step();
      chk("pre_rst_valid", 32'(bus.res_valid), 32'd1);
      bus.req_valid = 4'b0100;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("mid_rst_res_data", 32'(bus.res_data), 32'd0);
      chk("mid_rst_res_id", 32'(bus.res_id), 32'd0);
      chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      bus.res_ready = 1'b1;
      rst_n         = 1'b1;
      res_cnt0      = res_cnt;
      repeat (6) step();
      chk("no_stale_result", 32'(res_cnt - res_cnt0), 32'd0);
      chk("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
